// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a ready-handshaked instruction memory and
// presents one instruction at a time to decode, with a one-entry skid buffer and redirect squashing.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCsrc,
   input  logic [31:0] PCalu,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc_out,
   output logic        inst_valid
);

   typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        squash_q, squash_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        inst_valid_q, inst_valid_d;
   logic        consume;

   assign consume = inst_valid_q && !stall;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      squash_d     = squash_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      inst_d       = inst_q;
      pc_out_d     = pc_out_q;
      inst_valid_d = inst_valid_q;

      unique case (state_q)
         IDLE: begin
            if (PCsrc) pc_d = PCalu;
            state_d = BUSY;
         end
         BUSY: begin
            if (PCsrc) begin
               // A redirect while waiting keeps the address on the bus and parks the target.
               inst_valid_d = 1'b0;
               if (imem_ready) begin
                  pc_d     = PCalu;
                  squash_d = 1'b0;
               end else begin
                  tgt_d    = PCalu;
                  squash_d = 1'b1;
               end
            end else if (imem_ready && !squash_q) begin
               pc_d = pc_q + PC_STEP;
               if (!inst_valid_q || !stall) begin
                  inst_d       = imem_rdata;
                  pc_out_d     = pc_q;
                  inst_valid_d = 1'b1;
               end else begin
                  skid_inst_d = imem_rdata;
                  skid_pc_d   = pc_q;
                  state_d     = FULL;
               end
            end else begin
               if (imem_ready) begin
                  pc_d     = tgt_q;
                  squash_d = 1'b0;
               end
               if (consume) inst_valid_d = 1'b0;
            end
         end
         FULL: begin
            if (PCsrc) begin
               inst_valid_d = 1'b0;
               pc_d         = PCalu;
               state_d      = BUSY;
            end else if (!stall) begin
               inst_d       = skid_inst_q;
               pc_out_d     = skid_pc_q;
               inst_valid_d = 1'b1;
               state_d      = BUSY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         tgt_q        <= '0;
         squash_q     <= 1'b0;
         skid_inst_q  <= '0;
         skid_pc_q    <= '0;
         inst_q       <= '0;
         pc_out_q     <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         squash_q     <= squash_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         inst_q       <= inst_d;
         pc_out_q     <= pc_out_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   // Request is also masked while rst is high so a reset mid-access drops the bus immediately.
   assign imem_req   = (state_q == BUSY) && !rst;
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign pc_out     = pc_out_q;
   assign inst_valid = inst_valid_q;

endmodule
